// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants: opcodes, ALUop encodings, immediate kinds
// and the control bundle carried through ID/EX.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // ALUop as understood by ALUControl
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

    // Immediate format selected by an opcode; R-type and unknown give none
    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        imm_type_e t;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: t = IMM_I;
            OPC_STORE:                      t = IMM_S;
            OPC_BRANCH:                     t = IMM_B;
            OPC_LUI, OPC_AUIPC:             t = IMM_U;
            OPC_JAL:                        t = IMM_J;
            default:                        t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: builds the sign-extended immediate
// for the format implied by the instruction's opcode.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    // Assemble the 32-bit immediate for the decoded format
    always_comb begin
        imm32 = '0;
        case (imm_type_of(instr_i[6:0]))
            IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Widen to the datapath, keeping the sign
    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes instr_i into controls and immediate,
// registers everything for EX, and raises a load-use stall request.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            hazard_stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [1:0]      ALUop_o,
    output logic [6:0]      func7_o,
    output logic [2:0]      func3_o,
    output logic            alu_src_o,
    output logic            reg_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            mem_to_reg_o,
    output logic            branch_o,
    output logic            jump_o
);

    logic [XLEN-1:0] imm_d;
    ctrl_t           ctrl_d;
    logic            valid_d;
    logic            known_op;
    logic            use_rs1;
    logic            use_rs2;

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    logic [6:0]      func7_q;
    logic [2:0]      func3_q;
    ctrl_t           ctrl_q;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (instr_i),
        .imm_o   (imm_d)
    );

    // Main decoder: controls plus which source registers the instruction reads
    always_comb begin
        ctrl_d   = '0;
        known_op = 1'b1;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (instr_i[6:0])
            OPC_OP: begin
                ctrl_d.alu_op    = ALUOP_RTYPE;
                ctrl_d.reg_write = 1'b1;
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl_d.alu_op    = ALUOP_ITYPE;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                use_rs1          = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                use_rs1           = 1'b1;
            end
            OPC_STORE: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_d.alu_op = ALUOP_BRANCH;
                ctrl_d.branch = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            OPC_JAL: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.jump      = 1'b1;
            end
            OPC_JALR: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.jump      = 1'b1;
                use_rs1          = 1'b1;
            end
            default: known_op = 1'b0;
        endcase

        // Unknown opcodes and invalid slots become bubbles
        valid_d = valid_i & known_op;
        if (!valid_d) begin
            ctrl_d = '0;
        end
    end

    // Load-use hazard: the load in EX writes a register this instruction reads
    always_comb begin
        hazard_stall_o = valid_q & ctrl_q.mem_read & (rd_q != 5'd0) & valid_i &
                         ((use_rs1 & (rd_q == instr_i[19:15])) |
                          (use_rs2 & (rd_q == instr_i[24:20])));
    end

    // Pipeline register: flush > stall > hazard bubble > normal load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            func7_q    <= '0;
            func3_q    <= '0;
            ctrl_q     <= '0;
        end else if (flush_i || (!stall_i && hazard_stall_o)) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            func7_q    <= '0;
            func3_q    <= '0;
            ctrl_q     <= '0;
        end else if (!stall_i) begin
            valid_q    <= valid_d;
            pc_q       <= pc_i;
            rs1_data_q <= rs1_data_i;
            rs2_data_q <= rs2_data_i;
            imm_q      <= imm_d;
            rs1_q      <= instr_i[19:15];
            rs2_q      <= instr_i[24:20];
            rd_q       <= instr_i[11:7];
            func7_q    <= instr_i[31:25];
            func3_q    <= instr_i[14:12];
            ctrl_q     <= ctrl_d;
        end
    end

    assign valid_o      = valid_q;
    assign pc_o         = pc_q;
    assign rs1_data_o   = rs1_data_q;
    assign rs2_data_o   = rs2_data_q;
    assign imm_o        = imm_q;
    assign rs1_o        = rs1_q;
    assign rs2_o        = rs2_q;
    assign rd_o         = rd_q;
    assign func7_o      = func7_q;
    assign func3_o      = func3_q;
    assign ALUop_o      = ctrl_q.alu_op;
    assign alu_src_o    = ctrl_q.alu_src;
    assign reg_write_o  = ctrl_q.reg_write;
    assign mem_read_o   = ctrl_q.mem_read;
    assign mem_write_o  = ctrl_q.mem_write;
    assign mem_to_reg_o = ctrl_q.mem_to_reg;
    assign branch_o     = ctrl_q.branch;
    assign jump_o       = ctrl_q.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a decode vector table plus hand-written
// sequences for reset, load-use hazard, flush and stall.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        valid_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        stall_i;
    logic        flush_i;
    logic        hazard_stall_o;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [31:0] imm_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    logic [1:0]  ALUop_o;
    logic [6:0]  func7_o;
    logic [2:0]  func3_o;
    logic        alu_src_o;
    logic        reg_write_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        mem_to_reg_o;
    logic        branch_o;
    logic        jump_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_i        (instr_i),
        .pc_i           (pc_i),
        .valid_i        (valid_i),
        .rs1_data_i     (rs1_data_i),
        .rs2_data_i     (rs2_data_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .hazard_stall_o (hazard_stall_o),
        .valid_o        (valid_o),
        .pc_o           (pc_o),
        .rs1_data_o     (rs1_data_o),
        .rs2_data_o     (rs2_data_o),
        .imm_o          (imm_o),
        .rs1_o          (rs1_o),
        .rs2_o          (rs2_o),
        .rd_o           (rd_o),
        .ALUop_o        (ALUop_o),
        .func7_o        (func7_o),
        .func3_o        (func3_o),
        .alu_src_o      (alu_src_o),
        .reg_write_o    (reg_write_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .mem_to_reg_o   (mem_to_reg_o),
        .branch_o       (branch_o),
        .jump_o         (jump_o)
    );

    // {alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, jump}
    wire [6:0] ctrl_o = {alu_src_o, reg_write_o, mem_read_o, mem_write_o,
                         mem_to_reg_o, branch_o, jump_o};

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        exp_valid;
        logic [1:0]  exp_aluop;
        logic [6:0]  exp_ctrl;
        logic [31:0] exp_imm;
        logic [4:0]  exp_rd;
        logic [2:0]  exp_f3;
        logic [6:0]  exp_f7;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic valid, input logic [31:0] pc);
        instr_i    = instr;
        valid_i    = valid;
        pc_i       = pc;
        rs1_data_i = 32'hA000_0000 | pc;
        rs2_data_i = 32'hB000_0000 | pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"}, 32'(valid_o), 32'd0);
        chk({tag, ".ctrl"},  32'(ctrl_o),  32'd0);
        chk({tag, ".aluop"}, 32'(ALUop_o), 32'd0);
        chk({tag, ".imm"},   imm_o,        32'd0);
        chk({tag, ".pc"},    pc_o,         32'd0);
        chk({tag, ".rd"},    32'(rd_o),    32'd0);
    endtask

    initial begin
        // instr, valid, exp_valid, aluop, ctrl, imm, rd, f3, f7
        vecs[0]  = '{32'h002081B3, 1'b1, 1'b1, 2'b10, 7'b0100000, 32'h00000000, 5'd3,  3'b000, 7'h00}; // add x3,x1,x2
        vecs[1]  = '{32'hFFF00293, 1'b1, 1'b1, 2'b11, 7'b1100000, 32'hFFFFFFFF, 5'd5,  3'b000, 7'h7F}; // addi x5,x0,-1
        vecs[2]  = '{32'h0080A283, 1'b1, 1'b1, 2'b00, 7'b1110100, 32'h00000008, 5'd5,  3'b010, 7'h00}; // lw x5,8(x1)
        vecs[3]  = '{32'h0020A623, 1'b1, 1'b1, 2'b00, 7'b1001000, 32'h0000000C, 5'd12, 3'b010, 7'h00}; // sw x2,12(x1)
        vecs[4]  = '{32'hFE208EE3, 1'b1, 1'b1, 2'b01, 7'b0000010, 32'hFFFFFFFC, 5'd29, 3'b000, 7'h7F}; // beq x1,x2,-4
        vecs[5]  = '{32'h123453B7, 1'b1, 1'b1, 2'b00, 7'b1100000, 32'h12345000, 5'd7,  3'b101, 7'h09}; // lui x7
        vecs[6]  = '{32'hFFFFF417, 1'b1, 1'b1, 2'b00, 7'b1100000, 32'hFFFFF000, 5'd8,  3'b111, 7'h7F}; // auipc x8
        vecs[7]  = '{32'h010000EF, 1'b1, 1'b1, 2'b00, 7'b1100001, 32'h00000010, 5'd1,  3'b000, 7'h00}; // jal x1,+16
        vecs[8]  = '{32'h00008067, 1'b1, 1'b1, 2'b00, 7'b1100001, 32'h00000000, 5'd0,  3'b000, 7'h00}; // jalr x0,0(x1)
        vecs[9]  = '{32'h0000007F, 1'b1, 1'b0, 2'b00, 7'b0000000, 32'h00000000, 5'd0,  3'b000, 7'h00}; // unknown opcode
        vecs[10] = '{32'h002081B3, 1'b0, 1'b0, 2'b00, 7'b0000000, 32'h00000000, 5'd3,  3'b000, 7'h00}; // add, valid_i=0
        vecs[11] = '{32'h40208133, 1'b1, 1'b1, 2'b10, 7'b0100000, 32'h00000000, 5'd2,  3'b000, 7'h20}; // sub x2,x1,x2

        rst_n   = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        drive(32'h002081B3, 1'b1, 32'h0);
        #2;
        chk_bubble("reset");
        chk("reset.hazard", 32'(hazard_stall_o), 32'd0);
        tick();
        chk("reset.held_valid", 32'(valid_o), 32'd0);
        #2 rst_n = 1'b1;

        // First edge after reset release loads normally
        tick();
        chk("post_reset.valid", 32'(valid_o), 32'd1);
        chk("post_reset.rd",    32'(rd_o),    32'd3);

        // Decode table
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].instr, vecs[i].valid, 32'h100 + 32'(i) * 4);
            #1;
            chk($sformatf("v%0d.hazard", i), 32'(hazard_stall_o), 32'd0);
            tick();
            chk($sformatf("v%0d.valid", i), 32'(valid_o), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d.aluop", i), 32'(ALUop_o), 32'(vecs[i].exp_aluop));
            chk($sformatf("v%0d.ctrl", i),  32'(ctrl_o),  32'(vecs[i].exp_ctrl));
            chk($sformatf("v%0d.imm", i),   imm_o,        vecs[i].exp_imm);
            chk($sformatf("v%0d.rd", i),    32'(rd_o),    32'(vecs[i].exp_rd));
            chk($sformatf("v%0d.f3", i),    32'(func3_o), 32'(vecs[i].exp_f3));
            chk($sformatf("v%0d.f7", i),    32'(func7_o), 32'(vecs[i].exp_f7));
            chk($sformatf("v%0d.pc", i),    pc_o,         32'h100 + 32'(i) * 4);
            chk($sformatf("v%0d.rs1d", i),  rs1_data_o,   32'hA000_0100 + 32'(i) * 4);
        end

        // Load-use hazard: lw x5 then add x6,x5,x2
        drive(32'h0080A283, 1'b1, 32'h200);
        tick();
        drive(32'h00228333, 1'b1, 32'h204);
        #1;
        chk("lu.hazard", 32'(hazard_stall_o), 32'd1);
        tick();
        chk("lu.bubble_valid", 32'(valid_o), 32'd0);
        chk("lu.bubble_ctrl",  32'(ctrl_o),  32'd0);
        chk("lu.hazard_clear", 32'(hazard_stall_o), 32'd0);
        tick();
        chk("lu.add_valid", 32'(valid_o), 32'd1);
        chk("lu.add_rd",    32'(rd_o),    32'd6);
        chk("lu.add_aluop", 32'(ALUop_o), 32'd2);
        chk("lu.add_pc",    pc_o,         32'h204);
        chk("lu.add_rs2",   32'(rs2_o),   32'd2);

        // lw x5 followed by addi x6,x1,5: imm bits alias rs2=x5 but I-type has no rs2
        drive(32'h0080A283, 1'b1, 32'h210);
        tick();
        drive(32'h00508313, 1'b1, 32'h214);
        #1;
        chk("lu.itype_rs2_alias", 32'(hazard_stall_o), 32'd0);
        // Same load, but the consumer slot is invalid
        drive(32'h00228333, 1'b0, 32'h214);
        #1;
        chk("lu.invalid_consumer", 32'(hazard_stall_o), 32'd0);

        // Load to x0 never stalls
        drive(32'h0080A003, 1'b1, 32'h220);
        tick();
        drive(32'h00200333, 1'b1, 32'h224);
        #1;
        chk("lu.x0_no_hazard", 32'(hazard_stall_o), 32'd0);
        tick();

        // Flush alone, then flush together with stall
        drive(32'h002081B3, 1'b1, 32'h300);
        flush_i = 1'b1;
        tick();
        chk_bubble("flush");
        flush_i = 1'b0;
        tick();
        chk("flush.reload", 32'(valid_o), 32'd1);
        flush_i = 1'b1;
        stall_i = 1'b1;
        tick();
        chk_bubble("flush_stall");
        flush_i = 1'b0;
        stall_i = 1'b0;

        // Stall for 3 cycles with changing instr_i
        drive(32'h0080A283, 1'b1, 32'h400);
        tick();
        stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(32'h00228333 + 32'(c) * 32'h80, 1'b1, 32'h404 + 32'(c) * 4);
            tick();
            chk($sformatf("stall%0d.valid", c), 32'(valid_o), 32'd1);
            chk($sformatf("stall%0d.ctrl", c),  32'(ctrl_o),  32'h74);
            chk($sformatf("stall%0d.rd", c),    32'(rd_o),    32'd5);
            chk($sformatf("stall%0d.imm", c),   imm_o,        32'd8);
            chk($sformatf("stall%0d.pc", c),    pc_o,         32'h400);
        end
        stall_i = 1'b0;
        drive(32'h00508313, 1'b1, 32'h410);
        tick();
        chk("unstall.rd",    32'(rd_o),    32'd6);
        chk("unstall.aluop", 32'(ALUop_o), 32'd3);
        chk("unstall.imm",   imm_o,        32'd5);

        // Asynchronous reset mid-cycle with a valid instruction loaded
        drive(32'h002081B3, 1'b1, 32'h500);
        tick();
        chk("areset.pre_valid", 32'(valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_bubble("areset");
        chk("areset.hazard", 32'(hazard_stall_o), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("areset.reload_valid", 32'(valid_o), 32'd1);
        chk("areset.reload_pc",    pc_o,         32'h500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
